dbus_align: RTL



---
 rtl/dbus_align.sv | 120 ++++++++++++
 1 files changed

// File: rtl/dbus_align.sv
// rtl/dbus_align.sv - load/store data-bus aligner with pipeline hold and load extension
module dbus_align (
    input  logic        SYSCLK,
    input  logic        RESET_D1_R_N,
    input  logic        MEM_REQ_E,
    input  logic        MEM_WR_E,
    input  logic [1:0]  MEM_SIZE_E,
    input  logic        MEM_SIGNED_E,
    input  logic [31:0] ADDR_E,
    input  logic [31:0] STDATA_E,
    input  logic        DBUS_ACK,
    input  logic        DBUS_ERR,
    input  logic [31:0] DBUS_RDATA,
    output logic        DBUS_REQ_R,
    output logic        DBUS_WR_R,
    output logic [31:0] DBUS_ADDR_R,
    output logic [3:0]  DBUS_BE_R,
    output logic [31:0] DBUS_WDATA_R,
    output logic [31:0] RDBUSINM,
    output logic        RDVALID_M,
    output logic        CLMI_RHOLD,
    output logic        ADDR_ERR_R,
    output logic        BUS_ERR_R
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state, state_nxt;
    logic        busy, accept, legal, misaligned, ld_done;
    logic [3:0]  be_nxt;
    logic [31:0] wdata_nxt, ld_data, ld_shift;
    logic [15:0] ld_half;
    logic [1:0]  size_q, lo_q;
    logic        signed_q;

    assign busy       = (state == BUSY);
    assign DBUS_REQ_R = busy;

    always_comb begin
        misaligned = 1'b0;
        be_nxt     = 4'b1111;
        wdata_nxt  = STDATA_E;
        case (MEM_SIZE_E)
            2'b00: begin
                be_nxt    = 4'b0001 << ADDR_E[1:0];
                wdata_nxt = {4{STDATA_E[7:0]}};
            end
            2'b01: begin
                misaligned = ADDR_E[0];
                be_nxt     = 4'b0011 << {ADDR_E[1], 1'b0};
                wdata_nxt  = {2{STDATA_E[15:0]}};
            end
            2'b10:   misaligned = |ADDR_E[1:0];
            default: misaligned = 1'b1;
        endcase
    end

    // A terminating bus cycle releases the hold, so a new request can issue in the same cycle.
    always_comb begin
        CLMI_RHOLD = busy & ~DBUS_ACK & ~DBUS_ERR;
        accept     = MEM_REQ_E & ~CLMI_RHOLD;
        legal      = accept & ~misaligned;
        state_nxt  = state;
        if (legal)
            state_nxt = BUSY;
        else if (busy & (DBUS_ACK | DBUS_ERR))
            state_nxt = IDLE;
    end

    always_ff @(posedge SYSCLK or negedge RESET_D1_R_N) begin
        if (!RESET_D1_R_N)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    assign ld_done  = busy & DBUS_ACK & ~DBUS_ERR & ~DBUS_WR_R;
    assign ld_shift = DBUS_RDATA >> {lo_q, 3'b000};
    assign ld_half  = lo_q[1] ? DBUS_RDATA[31:16] : DBUS_RDATA[15:0];

    always_comb begin
        case (size_q)
            2'b00:   ld_data = {{24{signed_q & ld_shift[7]}}, ld_shift[7:0]};
            2'b01:   ld_data = {{16{signed_q & ld_half[15]}}, ld_half};
            default: ld_data = DBUS_RDATA;
        endcase
    end

    always_ff @(posedge SYSCLK or negedge RESET_D1_R_N) begin
        if (!RESET_D1_R_N) begin
            DBUS_WR_R    <= 1'b0;
            DBUS_ADDR_R  <= 32'h0;
            DBUS_BE_R    <= 4'h0;
            DBUS_WDATA_R <= 32'h0;
            RDBUSINM     <= 32'h0;
            RDVALID_M    <= 1'b0;
            ADDR_ERR_R   <= 1'b0;
            BUS_ERR_R    <= 1'b0;
            size_q       <= 2'b00;
            lo_q         <= 2'b00;
            signed_q     <= 1'b0;
        end else begin
            RDVALID_M  <= ld_done;
            ADDR_ERR_R <= accept & misaligned;
            BUS_ERR_R  <= busy & DBUS_ERR;
            if (ld_done)
                RDBUSINM <= ld_data;
            if (legal) begin
                DBUS_WR_R    <= MEM_WR_E;
                DBUS_ADDR_R  <= {ADDR_E[31:2], 2'b00};
                DBUS_BE_R    <= be_nxt;
                DBUS_WDATA_R <= wdata_nxt;
                size_q       <= MEM_SIZE_E;
                lo_q         <= ADDR_E[1:0];
                signed_q     <= MEM_SIGNED_E;
            end
        end
    end

endmodule
